ps2_mouse_tracker: RTL and testbench

Next-generation PS/2 mouse controller sitting between the ps2_rxtx transceiver and the VGA cursor/pointer logic. It runs a checked, retried initialisation sequence, which is reset, then set stream mode, then enable reporting. It decodes 3-byte packets with sync checking and timeout resynchronisation, and accumulates signed deltas into an absolute, screen-clamped cursor position. It also reports three buttons and raw deltas.

---
 rtl/ps2_mouse_tracker.sv | 190 +++++++++++++++++++
 tb/tb_ps2_mouse_tracker.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_mouse_tracker.sv
// PS/2 mouse controller: retried init (reset, stream mode, enable), 3-byte packet decode
// with resync/timeout, and screen-clamped absolute cursor tracking.
module ps2_mouse_tracker #(
  parameter int POS_W       = 10,
  parameter int X_MAX       = 639,
  parameter int Y_MAX       = 479,
  parameter int TIMEOUT_CYC = 2500000,
  parameter int MAX_RETRY   = 3,
  parameter bit INIT_RESET  = 1'b1,
  parameter bit Y_INVERT    = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [7:0]       rx_data,
  input  logic             rx_done_tick,
  input  logic             tx_done_tick,
  output logic             wr_ps2,
  output logic [7:0]       tx_data,
  output logic [POS_W-1:0] xpos,
  output logic [POS_W-1:0] ypos,
  output logic [8:0]       dx,
  output logic [8:0]       dy,
  output logic [2:0]       btn,
  output logic             m_done_tick,
  output logic             init_ok,
  output logic             init_err
);

  localparam int W  = POS_W + 2;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int RW = $clog2(MAX_RETRY + 2);

  localparam logic [TW-1:0]         TMO_LAST  = TW'(TIMEOUT_CYC - 1);
  localparam logic [RW-1:0]         RETRY_LIM = RW'(MAX_RETRY);
  localparam logic [POS_W-1:0]      X_RST     = POS_W'(X_MAX / 2);
  localparam logic [POS_W-1:0]      Y_RST     = POS_W'(Y_MAX / 2);
  localparam logic signed [W-1:0]   X_MAX_S   = W'(X_MAX);
  localparam logic signed [W-1:0]   Y_MAX_S   = W'(Y_MAX);

  typedef enum logic [3:0] {
    RST_SEND, RST_WTX, RST_ACK, RST_BAT, RST_ID,
    STRM_SEND, STRM_WTX, STRM_ACK,
    EN_SEND, EN_WTX, EN_ACK,
    PACK1, PACK2, PACK3, DONE, ERR
  } state_t;

  state_t           state_q;
  logic [TW-1:0]    timer_q;
  logic [RW-1:0]    retry_q;
  logic             wr_q, mdone_q, init_ok_q, init_err_q;
  logic [7:0]       tx_q;
  logic [POS_W-1:0] xpos_q, ypos_q;
  logic [8:0]       dx_q, dy_q;
  logic [2:0]       btn_q;
  // First-byte fields kept until the packet completes: buttons, sign bits, overflow bits.
  logic [2:0]       hb_btn_q;
  logic [1:0]       hb_sgn_q, hb_ovf_q;
  logic [7:0]       b2_q, b3_q;

  logic             timed, timeout, give_up;
  logic [8:0]       dx_w, dy_w;
  logic signed [W-1:0] dx_ext, dy_ext, x_sum, y_sum;
  logic [POS_W-1:0] x_new, y_new;

  assign timed   = state_q inside {RST_ACK, RST_BAT, RST_ID, STRM_ACK, EN_ACK, PACK2, PACK3};
  assign timeout = timed && !rx_done_tick && (timer_q == TMO_LAST);
  assign give_up = (retry_q == RETRY_LIM);
  assign dx_w    = {hb_sgn_q[0], b2_q};
  assign dy_w    = {hb_sgn_q[1], b3_q};

  always_comb begin
    dx_ext = {{(W-9){dx_w[8]}}, dx_w};
    dy_ext = {{(W-9){dy_w[8]}}, dy_w};
    x_sum  = $signed({2'b00, xpos_q}) + dx_ext;
    if (Y_INVERT) y_sum = $signed({2'b00, ypos_q}) - dy_ext;
    else          y_sum = $signed({2'b00, ypos_q}) + dy_ext;

    if (x_sum[W-1])          x_new = '0;
    else if (x_sum > X_MAX_S) x_new = X_MAX_S[POS_W-1:0];
    else                     x_new = x_sum[POS_W-1:0];

    if (y_sum[W-1])          y_new = '0;
    else if (y_sum > Y_MAX_S) y_new = Y_MAX_S[POS_W-1:0];
    else                     y_new = y_sum[POS_W-1:0];
  end

  function automatic state_t retry_to(input state_t s);
    return give_up ? ERR : s;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= INIT_RESET ? RST_SEND : STRM_SEND;
      timer_q    <= '0;
      retry_q    <= '0;
      wr_q       <= 1'b0;
      mdone_q    <= 1'b0;
      init_ok_q  <= 1'b0;
      init_err_q <= 1'b0;
      tx_q       <= 8'h00;
      xpos_q     <= X_RST;
      ypos_q     <= Y_RST;
      dx_q       <= '0;
      dy_q       <= '0;
      btn_q      <= '0;
      hb_btn_q   <= '0;
      hb_sgn_q   <= '0;
      hb_ovf_q   <= '0;
      b2_q       <= '0;
      b3_q       <= '0;
    end else begin
      wr_q    <= 1'b0;
      mdone_q <= 1'b0;
      // Every exit from a timed state happens on rx or timeout, so this also clears on state change.
      timer_q <= (timed && !rx_done_tick && !timeout) ? timer_q + 1'b1 : '0;
      case (state_q)
        RST_SEND: begin wr_q <= 1'b1; tx_q <= 8'hFF; state_q <= RST_WTX; end
        RST_WTX:  if (tx_done_tick) state_q <= RST_ACK;
        RST_ACK:
          if (rx_done_tick && rx_data == 8'hFA) begin
            retry_q <= '0; state_q <= RST_BAT;
          end else if (rx_done_tick || timeout) begin
            retry_q <= retry_q + 1'b1; init_err_q <= give_up; state_q <= retry_to(RST_SEND);
          end
        RST_BAT:
          if (rx_done_tick && rx_data == 8'hAA) state_q <= RST_ID;
          else if (rx_done_tick || timeout) begin
            retry_q <= retry_q + 1'b1; init_err_q <= give_up; state_q <= retry_to(RST_SEND);
          end
        RST_ID:
          if (rx_done_tick) state_q <= STRM_SEND;
          else if (timeout) begin
            retry_q <= retry_q + 1'b1; init_err_q <= give_up; state_q <= retry_to(RST_SEND);
          end
        STRM_SEND: begin wr_q <= 1'b1; tx_q <= 8'hEA; state_q <= STRM_WTX; end
        STRM_WTX:  if (tx_done_tick) state_q <= STRM_ACK;
        STRM_ACK:
          if (rx_done_tick && rx_data == 8'hFA) begin
            retry_q <= '0; state_q <= EN_SEND;
          end else if (rx_done_tick || timeout) begin
            retry_q <= retry_q + 1'b1; init_err_q <= give_up; state_q <= retry_to(STRM_SEND);
          end
        EN_SEND: begin wr_q <= 1'b1; tx_q <= 8'hF4; state_q <= EN_WTX; end
        EN_WTX:  if (tx_done_tick) state_q <= EN_ACK;
        EN_ACK:
          if (rx_done_tick && rx_data == 8'hFA) begin
            retry_q <= '0; init_ok_q <= 1'b1; state_q <= PACK1;
          end else if (rx_done_tick || timeout) begin
            retry_q <= retry_q + 1'b1; init_err_q <= give_up; state_q <= retry_to(EN_SEND);
          end
        PACK1:
          if (rx_done_tick && rx_data[3]) begin
            hb_btn_q <= rx_data[2:0];
            hb_sgn_q <= rx_data[5:4];
            hb_ovf_q <= rx_data[7:6];
            state_q  <= PACK2;
          end
        PACK2:
          if (rx_done_tick) begin b2_q <= rx_data; state_q <= PACK3; end
          else if (timeout) state_q <= PACK1;
        PACK3:
          if (rx_done_tick) begin b3_q <= rx_data; state_q <= DONE; end
          else if (timeout) state_q <= PACK1;
        DONE: begin
          dx_q    <= dx_w;
          dy_q    <= dy_w;
          btn_q   <= hb_btn_q;
          if (!hb_ovf_q[0]) xpos_q <= x_new;
          if (!hb_ovf_q[1]) ypos_q <= y_new;
          mdone_q <= 1'b1;
          state_q <= PACK1;
        end
        ERR:     state_q <= ERR;
        default: state_q <= ERR;
      endcase
    end
  end

  assign wr_ps2      = wr_q;
  assign tx_data     = tx_q;
  assign xpos        = xpos_q;
  assign ypos        = ypos_q;
  assign dx          = dx_q;
  assign dy          = dy_q;
  assign btn         = btn_q;
  assign m_done_tick = mdone_q;
  assign init_ok     = init_ok_q;
  assign init_err    = init_err_q;

endmodule

// File: tb/tb_ps2_mouse_tracker.sv
// Bench for ps2_mouse_tracker: directed init/retry/resync steps plus random packets
// checked against an integer cursor model.
module tb_ps2_mouse_tracker;
  localparam int TMO = 200;
  localparam int XM  = 639;
  localparam int YM  = 479;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_done_tick = 1'b0;
  logic       tx_done_tick = 1'b0;
  logic       wr_ps2;
  logic [7:0] tx_data;
  logic [9:0] xpos, ypos;
  logic [8:0] dx, dy;
  logic [2:0] btn;
  logic       m_done_tick, init_ok, init_err;

  int checks = 0;
  int errors = 0;
  int mdone_cnt = 0;
  int wr_cnt = 0;

  int         mx, my, exp_done;
  logic [8:0] mdx, mdy;
  logic [2:0] mbtn;

  always #5 clk = ~clk;

  ps2_mouse_tracker #(.TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_done_tick(rx_done_tick),
    .tx_done_tick(tx_done_tick), .wr_ps2(wr_ps2), .tx_data(tx_data), .xpos(xpos),
    .ypos(ypos), .dx(dx), .dy(dy), .btn(btn), .m_done_tick(m_done_tick),
    .init_ok(init_ok), .init_err(init_err)
  );

  always @(negedge clk) begin
    if (m_done_tick) mdone_cnt++;
    if (wr_ps2) wr_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_done_tick = 1'b1;
    @(negedge clk);
    rx_done_tick = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Wait (bounded) for a command strobe, check its byte, then acknowledge the transmit.
  task automatic do_cmd(input logic [7:0] exp, input int bound);
    bit         seen = 1'b0;
    logic [7:0] got = 8'h00;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk);
      if (wr_ps2) begin seen = 1'b1; got = tx_data; end
    end
    chk("wr_seen", {31'b0, seen}, 32'd1);
    chk("tx_data", {24'b0, got}, {24'b0, exp});
    idle(2);
    tx_done_tick = 1'b1;
    @(negedge clk);
    tx_done_tick = 1'b0;
  endtask

  function automatic int clampi(input int v, input int hi);
    return (v < 0) ? 0 : ((v > hi) ? hi : v);
  endfunction

  task automatic model_pkt(input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
    int sdx, sdy;
    sdx = b1[4] ? int'(b2) - 256 : int'(b2);
    sdy = b1[5] ? int'(b3) - 256 : int'(b3);
    mdx = {b1[4], b2};
    mdy = {b1[5], b3};
    mbtn = b1[2:0];
    if (!b1[6]) mx = clampi(mx + sdx, XM);
    if (!b1[7]) my = clampi(my - sdy, YM);
    exp_done++;
  endtask

  task automatic packet(input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
    send_byte(b1); idle($urandom_range(0, 5));
    send_byte(b2); idle($urandom_range(0, 5));
    send_byte(b3);
    idle(4);
    model_pkt(b1, b2, b3);
    chk("xpos", 32'(xpos), 32'(mx));
    chk("ypos", 32'(ypos), 32'(my));
    chk("dx", 32'(dx), 32'(mdx));
    chk("dy", 32'(dy), 32'(mdy));
    chk("btn", 32'(btn), 32'(mbtn));
    chk("m_done_count", 32'(mdone_cnt), 32'(exp_done));
  endtask

  task automatic chk_reset_vals();
    chk("rst_xpos", 32'(xpos), 32'd319);
    chk("rst_ypos", 32'(ypos), 32'd239);
    chk("rst_dx", 32'(dx), 32'd0);
    chk("rst_dy", 32'(dy), 32'd0);
    chk("rst_btn", 32'(btn), 32'd0);
    chk("rst_wr", 32'(wr_ps2), 32'd0);
    chk("rst_mdone", 32'(m_done_tick), 32'd0);
    chk("rst_init_ok", 32'(init_ok), 32'd0);
    chk("rst_init_err", 32'(init_err), 32'd0);
  endtask

  initial begin
    logic [7:0] rb1, rb2, rb3;
    int w0;

    idle(3);
    chk_reset_vals();
    reset_n = 1'b1;

    // Happy-path initialisation
    do_cmd(8'hFF, 100);
    send_byte(8'hFA); send_byte(8'hAA); send_byte(8'h00);
    do_cmd(8'hEA, 100);
    send_byte(8'hFA);
    do_cmd(8'hF4, 100);
    send_byte(8'hFA);
    idle(2);
    chk("init_ok", 32'(init_ok), 32'd1);
    chk("init_err", 32'(init_err), 32'd0);

    mx = 319; my = 239; exp_done = 0; mdone_cnt = 0;

    packet(8'h08, 8'h05, 8'h03);
    chk("pkt1_x", 32'(xpos), 32'd324);
    chk("pkt1_y", 32'(ypos), 32'd236);
    packet(8'h39, 8'hFB, 8'hFE);
    chk("pkt2_x", 32'(xpos), 32'd319);
    chk("pkt2_y", 32'(ypos), 32'd238);
    chk("pkt2_dx", 32'(dx), 32'h1FB);
    chk("pkt2_btn", 32'(btn), 32'd1);

    // Walk up to x=635, then clamp and overflow cases
    packet(8'h08, 8'h7F, 8'h00);
    packet(8'h08, 8'h7F, 8'h00);
    packet(8'h08, 8'h3E, 8'h00);
    chk("x_635", 32'(xpos), 32'd635);
    packet(8'h08, 8'h10, 8'h00);
    chk("x_clamp", 32'(xpos), 32'd639);
    packet(8'h48, 8'hFF, 8'h00);
    chk("x_ovf_hold", 32'(xpos), 32'd639);
    chk("x_ovf_dx", 32'(dx), 32'h0FF);

    // Resync on a header without bit3
    send_byte(8'h05);
    packet(8'h08, 8'h01, 8'h01);
    chk("resync_dx", 32'(dx), 32'd1);

    // Partial packet abandoned by timeout
    send_byte(8'h08); send_byte(8'h02);
    idle(TMO + 5);
    chk("timeout_no_done", 32'(mdone_cnt), 32'(exp_done));
    packet(8'h08, 8'h01, 8'h01);
    chk("timeout_next_dx", 32'(dx), 32'd1);

    for (int i = 0; i < 40; i++) begin
      rb1 = 8'($urandom);
      rb1[3] = 1'b1;
      rb2 = 8'($urandom);
      rb3 = 8'($urandom);
      packet(rb1, rb2, rb3);
    end

    // Reset in the middle of a packet
    send_byte(8'h08); send_byte(8'h05);
    reset_n = 1'b0;
    #1;
    chk_reset_vals();
    idle(2);
    reset_n = 1'b1;
    do_cmd(8'hFF, 100);

    // Unanswered reset command is resent after a timeout
    do_cmd(8'hFF, TMO + 50);
    send_byte(8'hFA); send_byte(8'hAA); send_byte(8'h00);

    // Stream-mode command rejected four times exhausts retries
    for (int i = 0; i < 4; i++) begin
      do_cmd(8'hEA, 100);
      send_byte(8'hFE);
    end
    idle(3);
    chk("init_err_set", 32'(init_err), 32'd1);
    chk("init_ok_low", 32'(init_ok), 32'd0);
    w0 = wr_cnt;
    idle(1000);
    chk("no_wr_after_err", 32'(wr_cnt), 32'(w0));
    chk("init_err_held", 32'(init_err), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
